// File: rtl/fx3_host_reader_if.sv
// Bundle of the FX3 host reader handshake/data signals.
//   master : FPGA-side / host control view (drives start/stop/data, observes status)
//   slave  : the fx3_host_reader block itself
// Words are carried as raw 16-bit vectors; the sample is interpreted as signed
// only by whoever consumes wordData.
interface fx3_host_reader_if;
    // control and FPGA-side inputs to the reader
    logic        start;
    logic        stop;
    logic        testModeEnable;
    logic        dataAvailable;
    logic        bufferError;
    logic [15:0] databus;
    // reader outputs
    logic        collectData;
    logic        readData;
    logic        testMode;
    logic        wordValid;
    logic [15:0] wordData;
    logic        busy;
    logic [31:0] burstCount;
    logic [15:0] seqErrorCount;
    logic        bufferErrorSeen;

    modport master (
        output start, stop, testModeEnable, dataAvailable, bufferError, databus,
        input  collectData, readData, testMode, wordValid, wordData, busy,
        input  burstCount, seqErrorCount, bufferErrorSeen
    );

    modport slave (
        input  start, stop, testModeEnable, dataAvailable, bufferError, databus,
        output collectData, readData, testMode, wordValid, wordData, busy,
        output burstCount, seqErrorCount, bufferErrorSeen
    );
endinterface

// File: rtl/fx3_host_reader.sv
// FX3 host reader: pulls fixed-length bursts of 16-bit words from the FPGA side,
// captures them after a fixed read latency, and optionally checks a test pattern.
// Ports:
//   fx3_clock : sole clock, rising edge
//   nReset    : synchronous, active-low reset
//   bus       : fx3_host_reader_if.slave (start/stop/config/data in, strobes/status out)
// Session flow: IDLE -> WAIT_AVAIL -> READ (BURST_LEN strobes) -> DRAIN (READ_LATENCY)
// -> GAP (GAP_CYCLES) -> WAIT_AVAIL or IDLE. A stop seen mid-burst is deferred until
// the burst and its gap have finished.
module fx3_host_reader #(
    parameter int unsigned BURST_LEN    = 8192,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input logic              fx3_clock,
    input logic              nReset,
    fx3_host_reader_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StWaitAvail, StRead, StDrain, StGap} state_e;

    state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        stop_pend_q, stop_pend_d;
    logic        session_start;
    logic        burst_done;

    logic                    read_data;
    logic                    busy;
    logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [15:0]             word_q;
    logic                    test_mode_q;
    logic [31:0]             burst_cnt_q;
    logic [15:0]             seq_err_q;
    logic                    buf_err_q;
    logic                    seeded_q;
    logic [9:0]              exp_q;
    logic [9:0]              sample;
    logic                    mismatch;
    logic                    word_valid;

    // Next-state logic; one counter is reused for the READ, DRAIN and GAP phases.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stop_pend_d   = stop_pend_q;
        session_start = 1'b0;
        burst_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    session_start = 1'b1;
                    stop_pend_d   = 1'b0;
                    state_d       = StWaitAvail;
                end
            end
            StWaitAvail: begin
                // stop takes priority over a simultaneous dataAvailable
                if (bus.stop || stop_pend_q) begin
                    stop_pend_d = 1'b0;
                    state_d     = StIdle;
                end else if (bus.dataAvailable) begin
                    cnt_d   = 32'd0;
                    state_d = StRead;
                end
            end
            StRead: begin
                stop_pend_d = stop_pend_q | bus.stop;
                if (cnt_q == 32'(BURST_LEN - 1)) begin
                    cnt_d   = 32'd0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDrain: begin
                stop_pend_d = stop_pend_q | bus.stop;
                if (cnt_q == 32'(READ_LATENCY - 1)) begin
                    cnt_d      = 32'd0;
                    burst_done = 1'b1;
                    state_d    = StGap;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StGap: begin
                stop_pend_d = stop_pend_q | bus.stop;
                if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                    cnt_d = 32'd0;
                    if (stop_pend_q || bus.stop) begin
                        stop_pend_d = 1'b0;
                        state_d     = StIdle;
                    end else begin
                        state_d = StWaitAvail;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                stop_pend_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign read_data = (state_q == StRead);

    // Delay line modelling the FPGA-side read latency; its last stage marks valid words.
    always_comb begin
        rd_pipe_d    = rd_pipe_q;
        rd_pipe_d[0] = read_data;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    assign word_valid = rd_pipe_q[READ_LATENCY-1];

    // Test pattern: 10-bit sample sits in the top bits with its MSB inverted.
    assign sample   = {~word_q[15], word_q[14:6]};
    assign mismatch = (word_q[5:0] != 6'd0) || (seeded_q && (sample != exp_q));

    always_ff @(posedge fx3_clock) begin
        if (!nReset) begin
            state_q     <= StIdle;
            cnt_q       <= 32'd0;
            stop_pend_q <= 1'b0;
            rd_pipe_q   <= '0;
            word_q      <= 16'd0;
            test_mode_q <= 1'b0;
            burst_cnt_q <= 32'd0;
            seq_err_q   <= 16'd0;
            buf_err_q   <= 1'b0;
            seeded_q    <= 1'b0;
            exp_q       <= 10'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            rd_pipe_q   <= rd_pipe_d;
            // Register the bus word on the cycle it becomes valid at the output.
            if (rd_pipe_d[READ_LATENCY-1]) begin
                word_q <= bus.databus;
            end
            if (session_start) begin
                test_mode_q <= bus.testModeEnable;
                burst_cnt_q <= 32'd0;
                seq_err_q   <= 16'd0;
                buf_err_q   <= 1'b0;
                seeded_q    <= 1'b0;
            end else begin
                if (burst_done) begin
                    burst_cnt_q <= burst_cnt_q + 32'd1;
                end
                if (bus.bufferError && busy) begin
                    buf_err_q <= 1'b1;
                end
                // Expected value always follows the received sample, so a mismatch re-seeds.
                if (word_valid && test_mode_q) begin
                    seeded_q <= 1'b1;
                    exp_q    <= sample + 10'd1;
                    if (mismatch && (seq_err_q != 16'hFFFF)) begin
                        seq_err_q <= seq_err_q + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.collectData     = busy;
    assign bus.readData        = read_data;
    assign bus.testMode        = test_mode_q;
    assign bus.wordValid       = word_valid;
    assign bus.wordData        = word_q;
    assign bus.busy            = busy;
    assign bus.burstCount      = burst_cnt_q;
    assign bus.seqErrorCount   = seq_err_q;
    assign bus.bufferErrorSeen = buf_err_q;

endmodule

// File: tb/tb_fx3_host_reader.sv
// Self-checking bench for fx3_host_reader: directed session steps with randomized
// word patterns, checked against a pattern-level reference model.
module tb_fx3_host_reader;
    localparam int unsigned BL = 1024;
    localparam int unsigned RL = 2;
    localparam int unsigned GC = 4;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    fx3_host_reader_if bus ();

    fx3_host_reader #(
        .BURST_LEN   (BL),
        .READ_LATENCY(RL),
        .GAP_CYCLES  (GC)
    ) dut (
        .fx3_clock(clk),
        .nReset   (n_reset),
        .bus      (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [15:0] pat [$];
    logic        sess_clr = 1'b0;

    // FPGA-side source: a word is consumed per readData cycle and shows on databus
    // READ_LATENCY-1 cycles later, so it reaches wordData READ_LATENCY cycles after.
    bit          rd_seen = 1'b0;
    int unsigned rd_idx  = 0;
    always @(posedge clk) begin
        #1;
        if (sess_clr) begin
            rd_idx = 0;
        end else if (rd_seen) begin
            bus.databus = (rd_idx < pat.size()) ? pat[rd_idx] : 16'h0000;
            rd_idx++;
        end else if (rd_idx == 0) begin
            bus.databus = 16'h0000;
        end
    end

    // Output monitor: burst lengths, word latency, word contents, busy fall time.
    int unsigned cyc = 0;
    int unsigned rd_start = 0, rd_run = 0, rd_runs = 0, rd_len_bad = 0, rd_last = 0;
    int unsigned wv_cnt = 0, wv_off_bad = 0, wv_idx = 0, data_err = 0, busy_fall = 0;
    logic rd_prev = 1'b0, wv_prev = 1'b0, busy_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (sess_clr) begin
            rd_runs = 0; rd_len_bad = 0; wv_cnt = 0; wv_off_bad = 0; wv_idx = 0;
            data_err = 0;
        end else begin
            if (bus.readData === 1'b1) begin
                if (!rd_prev) begin
                    rd_start = cyc;
                    rd_run   = 0;
                end
                rd_run++;
                rd_last = cyc;
            end else if (rd_prev) begin
                rd_runs++;
                if (rd_run != BL) rd_len_bad++;
            end
            if (bus.wordValid === 1'b1) begin
                if (!wv_prev && (cyc - rd_start != RL)) wv_off_bad++;
                wv_cnt++;
                if (wv_idx >= pat.size() || bus.wordData !== pat[wv_idx]) data_err++;
                wv_idx++;
            end
            if (busy_prev && bus.busy === 1'b0) busy_fall = cyc;
        end
        rd_prev   = (bus.readData === 1'b1);
        wv_prev   = (bus.wordValid === 1'b1);
        busy_prev = (bus.busy === 1'b1);
        rd_seen   = (bus.readData === 1'b1);
    end

    // Reference: count test-pattern errors over the first n words of a session.
    function automatic int unsigned model_errs(input logic [15:0] w [$], input int unsigned n);
        int unsigned errs = 0;
        int unsigned prev = 0;
        bit          seeded = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            logic [15:0] x = w[i];
            int unsigned s = int'({~x[15], x[14:6]});
            if (x[5:0] != 6'd0 || (seeded && s != (prev + 1) % 1024)) begin
                if (errs < 65535) errs++;
            end
            prev   = s;
            seeded = 1'b1;
        end
        return errs;
    endfunction

    function automatic logic [15:0] mk(input int unsigned s, input logic [5:0] low);
        logic [9:0] v = s[9:0];
        return {~v[9], v[8:0], low};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic new_session();
        sess_clr = 1'b1;
        tick(2);
        sess_clr = 1'b0;
        tick(1);
    endtask

    task automatic wait_burst(input string tag, input logic [31:0] target);
        int unsigned k = 0;
        while (bus.burstCount !== target && k < 4 * BL) begin
            @(negedge clk);
            k++;
        end
        if (bus.burstCount !== target) chk({tag, " burst timeout"}, bus.burstCount, target);
    endtask

    task automatic wait_read(input string tag);
        int unsigned k = 0;
        while (bus.readData !== 1'b1 && k < 4 * BL) begin
            @(negedge clk);
            k++;
        end
        if (bus.readData !== 1'b1) chk({tag, " read timeout"}, 32'(bus.readData), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k = 0;
        while (bus.busy !== 1'b0 && k < 4 * BL) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy !== 1'b0) chk({tag, " idle timeout"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;
        int unsigned wv_before;
        bit          skipped;

        n_reset            = 1'b0;
        bus.start          = 1'b0;
        bus.stop           = 1'b0;
        bus.testModeEnable = 1'b0;
        bus.dataAvailable  = 1'b0;
        bus.bufferError    = 1'b0;
        tick(3);

        // Reset state
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst collectData", 32'(bus.collectData), 32'd0);
        chk("rst readData", 32'(bus.readData), 32'd0);
        chk("rst wordValid", 32'(bus.wordValid), 32'd0);
        chk("rst burstCount", bus.burstCount, 32'd0);
        chk("rst seqErrorCount", 32'(bus.seqErrorCount), 32'd0);
        chk("rst bufferErrorSeen", 32'(bus.bufferErrorSeen), 32'd0);
        chk("rst testMode", 32'(bus.testMode), 32'd0);

        // Stays idle after release; stop and bufferError in IDLE have no effect
        n_reset = 1'b1;
        bus.dataAvailable = 1'b1;
        tick(2);
        pulse_stop();
        bus.bufferError = 1'b1;
        tick(1);
        bus.bufferError = 1'b0;
        tick(4);
        chk("idle busy", 32'(bus.busy), 32'd0);
        chk("idle bufErr", 32'(bus.bufferErrorSeen), 32'd0);
        chk("idle readData", 32'(bus.readData), 32'd0);

        // Session A: incrementing pattern from 0, two bursts, 1023->0 at the boundary
        pat.delete();
        for (int unsigned i = 0; i < 2 * BL; i++) pat.push_back(mk(i % 1024, 6'd0));
        new_session();
        bus.testModeEnable = 1'b1;
        pulse_start();
        bus.testModeEnable = 1'b0;
        chk("A wait collect", 32'(bus.collectData), 32'd1);
        chk("A wait readData", 32'(bus.readData), 32'd0);
        wait_burst("A1", 32'd1);
        pulse_start();  // ignored while busy
        wait_read("A2");
        tick(10);
        pulse_stop();
        wait_idle("A");
        tick(2);
        chk("A busy", 32'(bus.busy), 32'd0);
        chk("A collectData", 32'(bus.collectData), 32'd0);
        chk("A burstCount", bus.burstCount, 32'd2);
        chk("A seqErr", 32'(bus.seqErrorCount), 32'(model_errs(pat, 2 * BL)));
        chk("A testMode", 32'(bus.testMode), 32'd1);
        chk("A bursts", rd_runs, 32'd2);
        chk("A burst len bad", rd_len_bad, 32'd0);
        chk("A words", wv_cnt, 2 * BL);
        chk("A latency bad", wv_off_bad, 32'd0);
        chk("A data err", data_err, 32'd0);
        chk("A drain+gap", busy_fall - rd_last, RL + GC + 1);

        // Session B: seeds at 1000, skips 101, then a randomly perturbed burst
        pat.delete();
        s = 1000;
        skipped = 1'b0;
        for (int unsigned i = 0; i < BL; i++) begin
            pat.push_back(mk(s % 1024, 6'd0));
            if (!skipped && s % 1024 == 100) begin
                s += 2;
                skipped = 1'b1;
            end else begin
                s += 1;
            end
        end
        for (int unsigned i = 0; i < 2 * BL; i++) begin
            logic [5:0] low = 6'd0;
            if ($urandom_range(99) < 3) low = 6'($urandom_range(63, 1));
            if ($urandom_range(99) < 2) s += $urandom_range(50, 2);
            if (i < BL) pat.push_back(mk(s % 1024, low));
            s += 1;
        end
        new_session();
        bus.testModeEnable = 1'b1;
        pulse_start();
        bus.testModeEnable = 1'b0;
        wait_burst("B1", 32'd1);
        bus.bufferError = 1'b1;  // first GAP cycle
        tick(1);
        bus.bufferError = 1'b0;
        tick(1);
        chk("B bufErr set", 32'(bus.bufferErrorSeen), 32'd1);
        chk("B skip errs", 32'(bus.seqErrorCount), 32'd1);
        chk("B model1", 32'(bus.seqErrorCount), 32'(model_errs(pat, BL)));
        wait_read("B2");
        tick(10);
        pulse_stop();
        wait_idle("B");
        tick(2);
        chk("B seqErr", 32'(bus.seqErrorCount), 32'(model_errs(pat, 2 * BL)));
        chk("B bufErr hold", 32'(bus.bufferErrorSeen), 32'd1);
        chk("B burstCount", bus.burstCount, 32'd2);
        chk("B data err", data_err, 32'd0);

        // Session C: test mode off, random words
        pat.delete();
        for (int unsigned i = 0; i < BL; i++) pat.push_back(16'($urandom));
        new_session();
        pulse_start();
        tick(1);
        chk("C bufErr cleared", 32'(bus.bufferErrorSeen), 32'd0);
        chk("C testMode", 32'(bus.testMode), 32'd0);
        wait_read("C");
        tick(10);
        pulse_stop();
        wait_idle("C");
        tick(2);
        chk("C seqErr", 32'(bus.seqErrorCount), 32'd0);
        chk("C burstCount", bus.burstCount, 32'd1);
        chk("C words", wv_cnt, BL);
        chk("C data err", data_err, 32'd0);
        bus.bufferError = 1'b1;
        tick(1);
        bus.bufferError = 1'b0;
        tick(1);
        chk("C idle bufErr", 32'(bus.bufferErrorSeen), 32'd0);

        // Session D: reset at READ cycle 500 of the second burst
        pat.delete();
        s = $urandom_range(1023);
        for (int unsigned i = 0; i < 2 * BL; i++) pat.push_back(mk((s + i) % 1024, 6'd0));
        new_session();
        bus.testModeEnable = 1'b1;
        pulse_start();
        bus.testModeEnable = 1'b0;
        wait_burst("D", 32'd1);
        wait_read("D");
        tick(500);
        n_reset = 1'b0;
        tick(1);
        chk("D readData", 32'(bus.readData), 32'd0);
        chk("D wordValid", 32'(bus.wordValid), 32'd0);
        chk("D burstCount", bus.burstCount, 32'd0);
        chk("D busy", 32'(bus.busy), 32'd0);
        chk("D collectData", 32'(bus.collectData), 32'd0);
        chk("D testMode", 32'(bus.testMode), 32'd0);
        n_reset = 1'b1;
        wv_before = wv_cnt;
        tick(5);
        chk("D pipe flushed", wv_cnt - wv_before, 32'd0);
        chk("D stays idle", 32'(bus.busy), 32'd0);

        // Session E: stop wins over dataAvailable in WAIT_AVAIL
        bus.dataAvailable = 1'b0;
        new_session();
        pulse_start();
        tick(3);
        chk("E collect", 32'(bus.collectData), 32'd1);
        chk("E busy", 32'(bus.busy), 32'd1);
        bus.dataAvailable = 1'b1;
        pulse_stop();
        chk("E stop busy", 32'(bus.busy), 32'd0);
        tick(3);
        chk("E no read", rd_runs + 32'(bus.readData), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
